// File: rtl/game_turn_manager.sv
`default_nettype none
// ============================================================================
// Module   : game_turn_manager
// Purpose  : Two-player turn sequencer. It runs per-turn timers and a settle
//            gap between turns. It resolves each shot against the opponent's
//            hit box, applies saturating damage and declares the winner.
// Revision : 1.0 - initial release
// ============================================================================
module game_turn_manager #(
  parameter int TURN_FRAMES   = 600,
  parameter int SETTLE_FRAMES = 30,
  parameter int HP_INIT       = 100,
  parameter int DMG_NORMAL    = 10,
  parameter int DMG_HEAVY     = 25,
  parameter int R_NORMAL      = 16,
  parameter int R_HEAVY       = 8
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start_game,
  input  logic       p1_fire_on,
  input  logic       p2_fire_on,
  input  logic       p1_weapon_mode,
  input  logic       p2_weapon_mode,
  input  logic [9:0] impact_x,
  input  logic [9:0] impact_y,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  output logic [1:0] game_turn,
  output logic [6:0] p1_hp,
  output logic [6:0] p2_hp,
  output logic [9:0] turn_timer,
  output logic       hit_flash,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_P1_TURN    = 3'd1;
  localparam logic [2:0] S_P1_RESOLVE = 3'd2;
  localparam logic [2:0] S_SETTLE     = 3'd3;
  localparam logic [2:0] S_P2_TURN    = 3'd4;
  localparam logic [2:0] S_P2_RESOLVE = 3'd5;
  localparam logic [2:0] S_GAME_OVER  = 3'd6;

  localparam logic [9:0]  TIMER_LOAD  = 10'(TURN_FRAMES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_FRAMES - 1);
  localparam logic [6:0]  HP_LOAD     = 7'(HP_INIT);
  localparam logic [6:0]  DMG_N       = 7'(DMG_NORMAL);
  localparam logic [6:0]  DMG_H       = 7'(DMG_HEAVY);
  localparam logic [10:0] RAD_N       = 11'(R_NORMAL);
  localparam logic [10:0] RAD_H       = 11'(R_HEAVY);

  logic [2:0]  state, state_nxt;
  logic [9:0]  shot_x, shot_y, shot_x_nxt, shot_y_nxt;
  logic        shot_mode, shot_mode_nxt;
  logic        next_is_p2, next_is_p2_nxt;
  logic [15:0] settle_cnt, settle_nxt;
  logic [1:0]  game_turn_nxt, winner_nxt;
  logic [6:0]  p1_hp_nxt, p2_hp_nxt;
  logic [9:0]  timer_nxt;
  logic        flash_nxt, over_nxt;

  logic        resolving, resolving_p1, hit, opp_dead;
  logic [9:0]  opp_x, opp_y;
  logic [10:0] dx, dy, rad;
  logic [6:0]  opp_hp, dmg, opp_hp_after;

  // Shot resolution: widened unsigned distance test against the opponent box
  always_comb begin
    resolving    = (state == S_P1_RESOLVE) || (state == S_P2_RESOLVE);
    resolving_p1 = (state == S_P1_RESOLVE);
    opp_x        = resolving_p1 ? p2_pos_x : p1_pos_x;
    opp_y        = resolving_p1 ? p2_pos_y : p1_pos_y;
    dx           = ({1'b0, shot_x} >= {1'b0, opp_x}) ? ({1'b0, shot_x} - {1'b0, opp_x})
                                                     : ({1'b0, opp_x} - {1'b0, shot_x});
    dy           = ({1'b0, shot_y} >= {1'b0, opp_y}) ? ({1'b0, shot_y} - {1'b0, opp_y})
                                                     : ({1'b0, opp_y} - {1'b0, shot_y});
    rad          = shot_mode ? RAD_H : RAD_N;
    dmg          = shot_mode ? DMG_H : DMG_N;
    hit          = resolving && (dx <= rad) && (dy <= rad);
    opp_hp       = resolving_p1 ? p2_hp : p1_hp;
    opp_hp_after = hit ? ((opp_hp > dmg) ? (opp_hp - dmg) : 7'd0) : opp_hp;
    opp_dead     = (opp_hp_after == 7'd0);
  end

  // State register
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start_game) state_nxt = S_P1_TURN;
      S_P1_TURN:    if (p1_fire_on) state_nxt = S_P1_RESOLVE;
                    else if (turn_timer == 10'd0) state_nxt = S_SETTLE;
      S_P2_TURN:    if (p2_fire_on) state_nxt = S_P2_RESOLVE;
                    else if (turn_timer == 10'd0) state_nxt = S_SETTLE;
      S_P1_RESOLVE,
      S_P2_RESOLVE: state_nxt = opp_dead ? S_GAME_OVER : S_SETTLE;
      S_SETTLE:     if (settle_cnt == 16'd0) state_nxt = next_is_p2 ? S_P2_TURN : S_P1_TURN;
      S_GAME_OVER:  if (start_game) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output and of the captured shot
  always_comb begin
    game_turn_nxt = 2'b00;
    if (state_nxt == S_P1_TURN) game_turn_nxt = 2'b01;
    if (state_nxt == S_P2_TURN) game_turn_nxt = 2'b10;

    timer_nxt = 10'd0;
    if ((state_nxt == S_P1_TURN) || (state_nxt == S_P2_TURN))
      timer_nxt = (state == state_nxt) ? (turn_timer - 10'd1) : TIMER_LOAD;

    settle_nxt = 16'd0;
    if (state_nxt == S_SETTLE)
      settle_nxt = (state == S_SETTLE) ? (settle_cnt - 16'd1) : SETTLE_LOAD;

    p1_hp_nxt = p1_hp;
    p2_hp_nxt = p2_hp;
    if (((state == S_IDLE) || (state == S_GAME_OVER)) && start_game) begin
      p1_hp_nxt = HP_LOAD;
      p2_hp_nxt = HP_LOAD;
    end
    if (state == S_P1_RESOLVE) p2_hp_nxt = opp_hp_after;
    if (state == S_P2_RESOLVE) p1_hp_nxt = opp_hp_after;

    flash_nxt = hit;
    over_nxt  = (state_nxt == S_GAME_OVER);

    winner_nxt = 2'b00;
    if (state_nxt == S_GAME_OVER)
      winner_nxt = (state == S_GAME_OVER) ? winner : (resolving_p1 ? 2'b01 : 2'b10);

    shot_x_nxt    = shot_x;
    shot_y_nxt    = shot_y;
    shot_mode_nxt = shot_mode;
    if ((state == S_P1_TURN) && p1_fire_on) begin
      shot_x_nxt = impact_x; shot_y_nxt = impact_y; shot_mode_nxt = p1_weapon_mode;
    end
    if ((state == S_P2_TURN) && p2_fire_on) begin
      shot_x_nxt = impact_x; shot_y_nxt = impact_y; shot_mode_nxt = p2_weapon_mode;
    end

    next_is_p2_nxt = next_is_p2;
    if ((state == S_P1_TURN) && (state_nxt != S_P1_TURN)) next_is_p2_nxt = 1'b1;
    if ((state == S_P2_TURN) && (state_nxt != S_P2_TURN)) next_is_p2_nxt = 1'b0;
    if ((state == S_IDLE) || (state == S_GAME_OVER))      next_is_p2_nxt = 1'b0;
  end

  // Output and datapath registers
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      game_turn  <= 2'b00;
      p1_hp      <= HP_LOAD;
      p2_hp      <= HP_LOAD;
      turn_timer <= 10'd0;
      hit_flash  <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      settle_cnt <= 16'd0;
      shot_x     <= 10'd0;
      shot_y     <= 10'd0;
      shot_mode  <= 1'b0;
      next_is_p2 <= 1'b0;
    end else begin
      game_turn  <= game_turn_nxt;
      p1_hp      <= p1_hp_nxt;
      p2_hp      <= p2_hp_nxt;
      turn_timer <= timer_nxt;
      hit_flash  <= flash_nxt;
      game_over  <= over_nxt;
      winner     <= winner_nxt;
      settle_cnt <= settle_nxt;
      shot_x     <= shot_x_nxt;
      shot_y     <= shot_y_nxt;
      shot_mode  <= shot_mode_nxt;
      next_is_p2 <= next_is_p2_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_turn_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_turn_manager
// Purpose  : Self-checking bench for game_turn_manager. A turn-level model
//            predicts owner, timer countdown, settle gap, damage and winner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_turn_manager;

  localparam int TURN_FRAMES   = 600;
  localparam int SETTLE_FRAMES = 30;
  localparam int HP_INIT       = 100;
  localparam int DMG_NORMAL    = 10;
  localparam int DMG_HEAVY     = 25;
  localparam int R_NORMAL      = 16;
  localparam int R_HEAVY       = 8;

  logic       frame_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start_game = 1'b0;
  logic       p1_fire_on = 1'b0, p2_fire_on = 1'b0;
  logic       p1_weapon_mode = 1'b0, p2_weapon_mode = 1'b0;
  logic [9:0] impact_x = '0, impact_y = '0;
  logic [9:0] p1_pos_x = '0, p1_pos_y = '0, p2_pos_x = '0, p2_pos_y = '0;
  logic [1:0] game_turn, winner;
  logic [6:0] p1_hp, p2_hp;
  logic [9:0] turn_timer;
  logic       hit_flash, game_over;

  int vectors = 0;
  int miscompares = 0;
  int hp1 = HP_INIT;
  int hp2 = HP_INIT;

  game_turn_manager #(
    .TURN_FRAMES(TURN_FRAMES), .SETTLE_FRAMES(SETTLE_FRAMES), .HP_INIT(HP_INIT),
    .DMG_NORMAL(DMG_NORMAL), .DMG_HEAVY(DMG_HEAVY), .R_NORMAL(R_NORMAL), .R_HEAVY(R_HEAVY)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .start_game(start_game),
    .p1_fire_on(p1_fire_on), .p2_fire_on(p2_fire_on),
    .p1_weapon_mode(p1_weapon_mode), .p2_weapon_mode(p2_weapon_mode),
    .impact_x(impact_x), .impact_y(impact_y),
    .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
    .game_turn(game_turn), .p1_hp(p1_hp), .p2_hp(p2_hp), .turn_timer(turn_timer),
    .hit_flash(hit_flash), .game_over(game_over), .winner(winner)
  );

  // Free-running frame clock
  always #5 frame_clk = ~frame_clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic quiet();
    p1_fire_on = 1'b0;
    p2_fire_on = 1'b0;
    start_game = 1'b0;
  endtask

  // Random activity on inputs that must be ignored in the current phase
  task automatic noise();
    p1_fire_on     = 1'($urandom_range(0, 1));
    p2_fire_on     = 1'($urandom_range(0, 1));
    start_game     = ($urandom_range(0, 3) == 0);
    p1_weapon_mode = 1'($urandom_range(0, 1));
    p2_weapon_mode = 1'($urandom_range(0, 1));
    impact_x       = 10'($urandom_range(0, 1023));
    impact_y       = 10'($urandom_range(0, 1023));
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic check_quiet_state(input string tag, input int e1, input int e2);
    check_val({tag, "_turn"},   game_turn, 0);
    check_val({tag, "_p1hp"},   p1_hp, e1);
    check_val({tag, "_p2hp"},   p2_hp, e2);
    check_val({tag, "_timer"},  turn_timer, 0);
    check_val({tag, "_flash"},  hit_flash, 0);
    check_val({tag, "_over"},   game_over, 0);
    check_val({tag, "_winner"}, winner, 0);
  endtask

  task automatic start_from_idle();
    start_game = 1'b1;
    tick();
    quiet();
    hp1 = HP_INIT;
    hp2 = HP_INIT;
    check_val("start_owner", game_turn, 1);
    check_val("start_timer", turn_timer, TURN_FRAMES - 1);
    check_val("start_p1hp", p1_hp, hp1);
    check_val("start_p2hp", p2_hp, hp2);
    check_val("start_over", game_over, 0);
  endtask

  // One whole turn of player pl, entered in its first cycle; fire_at<0 = timeout
  task automatic play_turn(input int pl, input int fire_at, input bit mode,
                           input int ix, input int iy, output bit ended);
    int ox, oy, r, dmg;
    bit hit, fired;
    ended = 1'b0;
    fired = 1'b0;
    for (int k = 0; k < TURN_FRAMES && !fired; k++) begin
      check_val("turn_owner", game_turn, pl);
      check_val("turn_timer", turn_timer, TURN_FRAMES - 1 - k);
      check_val("turn_flash", hit_flash, 0);
      noise();
      if (pl == 1) p1_fire_on = 1'b0; else p2_fire_on = 1'b0;
      if (k == fire_at) begin
        fired = 1'b1;
        if (pl == 1) begin p1_fire_on = 1'b1; p1_weapon_mode = mode; end
        else         begin p2_fire_on = 1'b1; p2_weapon_mode = mode; end
        impact_x = 10'(ix);
        impact_y = 10'(iy);
      end
      tick();
      quiet();
    end
    if (fired) begin
      check_val("resolve_owner", game_turn, 0);
      check_val("resolve_timer", turn_timer, 0);
      check_val("resolve_flash", hit_flash, 0);
      noise();
      tick();
      quiet();
      ox  = (pl == 1) ? int'(p2_pos_x) : int'(p1_pos_x);
      oy  = (pl == 1) ? int'(p2_pos_y) : int'(p1_pos_y);
      r   = mode ? R_HEAVY : R_NORMAL;
      dmg = mode ? DMG_HEAVY : DMG_NORMAL;
      hit = (absdiff(ix, ox) <= r) && (absdiff(iy, oy) <= r);
      if (hit) begin
        if (pl == 1) hp2 = (hp2 > dmg) ? hp2 - dmg : 0;
        else         hp1 = (hp1 > dmg) ? hp1 - dmg : 0;
      end
      check_val("after_p1hp", p1_hp, hp1);
      check_val("after_p2hp", p2_hp, hp2);
      check_val("after_flash", hit_flash, int'(hit));
      if (((pl == 1) ? hp2 : hp1) == 0) begin
        check_val("over_flag", game_over, 1);
        check_val("over_winner", winner, pl);
        check_val("over_owner", game_turn, 0);
        ended = 1'b1;
        return;
      end
    end
    for (int s = 0; s < SETTLE_FRAMES; s++) begin
      check_val("settle_owner", game_turn, 0);
      check_val("settle_timer", turn_timer, 0);
      check_val("settle_over", game_over, 0);
      if (s > 0 || !fired) check_val("settle_flash", hit_flash, 0);
      if (s == 0) begin
        check_val("settle_p1hp", p1_hp, hp1);
        check_val("settle_p2hp", p2_hp, hp2);
      end
      noise();
      tick();
      quiet();
    end
    check_val("next_owner", game_turn, 3 - pl);
  endtask

  task automatic set_pos(input int ax, input int ay, input int bx, input int by);
    p1_pos_x = 10'(ax); p1_pos_y = 10'(ay);
    p2_pos_x = 10'(bx); p2_pos_y = 10'(by);
  endtask

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  initial begin
    bit ended;
    int pl, fire_at, ox, oy, rad, ix, iy, sel;
    bit mode;

    // Power-on reset
    tick(); tick();
    check_quiet_state("reset", HP_INIT, HP_INIT);
    Reset_n = 1'b1;
    tick();
    check_quiet_state("idle", HP_INIT, HP_INIT);

    // Directed game: hits, misses, boundaries, timeouts, saturation
    start_from_idle();
    set_pos(400, 400, 210, 305);
    play_turn(1, 3, 1'b0, 200, 300, ended);     // normal hit, p2 -> 90
    check_val("p2hp_first_hit", p2_hp, 90);
    play_turn(2, 0, 1'b1, 409, 400, ended);     // heavy, 9 px off: miss
    check_val("p1hp_after_miss", p1_hp, 100);
    play_turn(1, 5, 1'b1, 218, 297, ended);     // heavy, exactly 8 px: hit
    play_turn(2, -1, 1'b0, 0, 0, ended);        // P2 timeout
    play_turn(1, TURN_FRAMES - 1, 1'b0, 215, 310, ended); // fire at timer 0
    set_pos(1020, 400, 210, 305);
    play_turn(2, 2, 1'b0, 5, 400, ended);       // far apart, must not wrap
    play_turn(1, -1, 1'b0, 0, 0, ended);        // P1 timeout
    play_turn(2, 1, 1'b0, 1023, 395, ended);    // hit on p1
    play_turn(1, 0, 1'b1, 210, 305, ended);
    play_turn(2, 0, 1'b0, 0, 0, ended);
    play_turn(1, 0, 1'b1, 210, 305, ended);
    check_val("p2hp_low", p2_hp, 5);
    play_turn(2, 0, 1'b0, 0, 0, ended);
    play_turn(1, 0, 1'b1, 210, 305, ended);     // 5 - 25 saturates to 0
    check_val("game_ended", int'(ended), 1);
    check_val("p2hp_zero", p2_hp, 0);

    // GAME_OVER holds until start_game
    for (int i = 0; i < 5; i++) begin
      p1_fire_on = 1'($urandom_range(0, 1));
      p2_fire_on = 1'($urandom_range(0, 1));
      tick();
      quiet();
      check_val("hold_over", game_over, 1);
      check_val("hold_winner", winner, 1);
      check_val("hold_p2hp", p2_hp, 0);
      check_val("hold_p1hp", p1_hp, hp1);
      check_val("hold_owner", game_turn, 0);
    end
    start_game = 1'b1;
    tick();
    quiet();
    check_quiet_state("restart_idle", HP_INIT, HP_INIT);
    tick();
    check_val("idle_stays", game_turn, 0);

    // Asynchronous reset during SETTLE
    start_from_idle();
    set_pos(400, 400, 210, 305);
    p1_fire_on = 1'b1; p1_weapon_mode = 1'b0; impact_x = 10'd210; impact_y = 10'd305;
    tick(); quiet();
    tick();
    check_val("pre_reset_p2hp", p2_hp, 90);
    repeat (5) tick();
    #2 Reset_n = 1'b0;
    #1 check_quiet_state("async_settle", HP_INIT, HP_INIT);
    tick();
    Reset_n = 1'b1;
    repeat (SETTLE_FRAMES + 2) tick();
    check_quiet_state("post_settle_rst", HP_INIT, HP_INIT);

    // Asynchronous reset while a hit is being resolved
    start_from_idle();
    p1_fire_on = 1'b1; p1_weapon_mode = 1'b1; impact_x = 10'd210; impact_y = 10'd305;
    tick(); quiet();
    #2 Reset_n = 1'b0;
    #1 check_quiet_state("async_resolve", HP_INIT, HP_INIT);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    check_quiet_state("post_resolve_rst", HP_INIT, HP_INIT);

    // Randomized games against the turn-level model
    for (int g = 0; g < 3; g++) begin
      start_from_idle();
      pl = 1;
      ended = 1'b0;
      for (int t = 0; t < 40 && !ended; t++) begin
        set_pos($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023));
        mode = 1'($urandom_range(0, 1));
        sel  = $urandom_range(0, 15);
        fire_at = (sel == 0) ? -1 : ((sel == 1) ? TURN_FRAMES - 1 : $urandom_range(0, 20));
        ox  = (pl == 1) ? int'(p2_pos_x) : int'(p1_pos_x);
        oy  = (pl == 1) ? int'(p2_pos_y) : int'(p1_pos_y);
        rad = (mode ? R_HEAVY : R_NORMAL) + 2;
        if ($urandom_range(0, 4) == 0) begin
          ix = $urandom_range(0, 1023);
          iy = $urandom_range(0, 1023);
        end else begin
          ix = clamp10(ox + $urandom_range(0, 2 * rad) - rad);
          iy = clamp10(oy + $urandom_range(0, 2 * rad) - rad);
        end
        play_turn(pl, fire_at, mode, ix, iy, ended);
        pl = 3 - pl;
      end
      if (ended) begin
        start_game = 1'b1;
        tick();
        quiet();
        check_quiet_state("rand_restart", HP_INIT, HP_INIT);
      end else begin
        #2 Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        check_quiet_state("rand_reset", HP_INIT, HP_INIT);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_turn_manager.md
GAME_TURN_MANAGER -- requirements
Module: game_turn_manager

Interface
REQ-001 SHALL have parameter TURN_FRAMES, default 600, frames allowed per turn before forfeit.
REQ-002 SHALL have parameter SETTLE_FRAMES, default 30, frames with no player active between turns.
REQ-003 SHALL have parameter HP_INIT, default 100, starting hit points per player (max 127).
REQ-004 SHALL have parameters DMG_NORMAL/DMG_HEAVY, defaults 10/25, damage per hit for weapon_mode 0/1.
REQ-005 SHALL have parameters R_NORMAL/R_HEAVY, defaults 16/8, hit half-box size in pixels for weapon_mode 0/1.
REQ-006 SHALL have port frame_clk  input  1  the only clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port start_game  input  1  level; starts a game from IDLE, clears GAME_OVER.
REQ-009 SHALL have ports p1_fire_on, p2_fire_on  input  1 each  one-frame fire pulses from player weapon machines.
REQ-010 SHALL have ports p1_weapon_mode, p2_weapon_mode  input  1 each  weapon mode of the shot, sampled with fire.
REQ-011 SHALL have ports impact_x, impact_y  input  10 each  ball impact position, sampled with fire.
REQ-012 SHALL have ports p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y  input  10 each  character positions.
REQ-013 SHALL have port game_turn  output  2  00 none, 01 player 1 active, 10 player 2 active; 11 never driven.
REQ-014 SHALL have ports p1_hp, p2_hp  output  7 each  current hit points.
REQ-015 SHALL have port turn_timer  output  10  frames remaining in current turn, 0 outside turns.
REQ-016 SHALL have port hit_flash  output  1  one-cycle pulse when a shot damages the opponent.
REQ-017 SHALL have ports game_over  output  1  and winner  output  2  (01 P1, 10 P2, 00 none).

Function
REQ-018 SHALL implement states IDLE, P1_TURN, P1_RESOLVE, SETTLE, P2_TURN, P2_RESOLVE, GAME_OVER; all outputs registered.
REQ-019 IDLE: start_game=1 -> P1_TURN next cycle; p1_hp/p2_hp load HP_INIT, turn_timer loads TURN_FRAMES-1.
REQ-020 game_turn SHALL be 01 in P1_TURN, 10 in P2_TURN, 00 in every other state.
REQ-021 In Px_TURN, turn_timer SHALL decrement by 1 per cycle without fire.
REQ-022 In Px_TURN, a pulse on the active player's fire_on SHALL capture impact_x/y and that player's weapon_mode and go to Px_RESOLVE next cycle.
REQ-023 A fire_on from the inactive player, or any fire_on outside Px_TURN, SHALL be ignored.
REQ-024 If turn_timer=0 in Px_TURN with no active fire that cycle, next state SHALL be SETTLE with no damage; total turn length TURN_FRAMES cycles.
REQ-025 Active fire in the same cycle as turn_timer=0 SHALL take priority over timeout.
REQ-026 Px_RESOLVE (exactly one cycle) SHALL declare a hit iff |impact_x-opp_x|<=R and |impact_y-opp_y|<=R, using 11-bit unsigned-difference compare with no wrap; R per captured mode.
REQ-027 On hit, opponent hp SHALL drop by DMG per captured mode, saturating at 0, and hit_flash SHALL be high the following cycle only.
REQ-028 After Px_RESOLVE, if opponent hp is 0 -> GAME_OVER, winner = shooter, game_over=1; else -> SETTLE.
REQ-029 SETTLE SHALL last SETTLE_FRAMES cycles, turn_timer=0, then enter the other player's TURN with turn_timer=TURN_FRAMES-1.
REQ-030 Turn alternation SHALL persist through timeouts: P1 timeout leads to P2_TURN and vice versa.
REQ-031 GAME_OVER SHALL hold hp, winner, game_over until start_game=1, then go to IDLE with hp=HP_INIT, winner=00, game_over=0.
REQ-032 start_game SHALL be ignored in all states except IDLE and GAME_OVER.

Reset
REQ-033 Reset_n=0 SHALL immediately force IDLE, game_turn=00, p1_hp=p2_hp=HP_INIT, turn_timer=0, hit_flash=0, game_over=0, winner=00, regardless of state.
REQ-034 Reset mid-turn or mid-SETTLE SHALL discard captured shot data and settle count; no damage is applied after release.

Verification
REQ-035 start_game=1 from IDLE, P1 fires mode 0 with impact (200,300), p2 at (210,305) -> P1_RESOLVE, p2_hp 100->90, hit_flash one cycle, 30 cycles game_turn=00, then game_turn=10.
REQ-036 P2 fires mode 1 with impact 9 px from p1 in x -> miss, no hp change, hit_flash stays 0.
REQ-037 No fire in P1_TURN -> game_turn=01 for exactly 600 cycles, then SETTLE, then P2_TURN; p1_fire_on in the final cycle (timer=0) -> resolves instead.
REQ-038 p2_hp=5, P1 heavy hit -> p2_hp=0 (no wrap), GAME_OVER, winner=01; start_game -> IDLE, hp=100.
REQ-039 p2_fire_on pulses during P1_TURN and SETTLE -> ignored; Reset_n low during SETTLE -> all outputs at reset values asynchronously.
